// File: rtl/dds_tuning_ctrl_pkg.sv
// Shared constants for the DDS tuning controller and the phase accumulator it feeds:
// FSM encoding, pending-request bit positions and default step/limit values.
package dds_ctrl_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [31:0] DEF_STEP_COARSE = 32'd85899346;
  localparam logic [31:0] DEF_STEP_MICRO  = 32'd85899;
  localparam logic [31:0] DEF_STEP_NANO   = 32'd86;
  localparam logic [31:0] DEF_PHASE_STEP  = 32'h2000_0000;
  localparam logic [31:0] DEF_FREQ_MIN    = 32'd86;
  localparam logic [31:0] DEF_FREQ_MAX    = 32'h8000_0000;
  localparam logic [31:0] DEF_FREQ_RESET  = 32'd85899346;
  localparam int          DEF_ACK_TIMEOUT = 1024;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;
  localparam logic [1:0] ST_LOAD = 2'd3;

  // Lower index wins arbitration; even bits are "add", the odd neighbour is its "sub".
  localparam int          NUM_REQ        = 8;
  localparam logic [2:0]  IDX_COARSE_ADD = 3'd0;
  localparam logic [2:0]  IDX_COARSE_SUB = 3'd1;
  localparam logic [2:0]  IDX_MICRO_ADD  = 3'd2;
  localparam logic [2:0]  IDX_MICRO_SUB  = 3'd3;
  localparam logic [2:0]  IDX_NANO_ADD   = 3'd4;
  localparam logic [2:0]  IDX_NANO_SUB   = 3'd5;
  localparam logic [2:0]  IDX_PHASE_ADD  = 3'd6;
  localparam logic [2:0]  IDX_PHASE_SUB  = 3'd7;

  function automatic logic [2:0] pickRequest(input logic [NUM_REQ-1:0] pend);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dds_tuning_ctrl_if.sv
// Word-pair handoff between the tuning controller (master) and the phase accumulator (slave).
interface dds_tuning_ctrl_if
  import dds_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] FreqWord;
  logic [WIDTH-1:0] PhaseWord;
  logic             Load;
  logic             LoadAck;
  logic             AtLimit;

  modport master (output FreqWord, output PhaseWord, output Load, output AtLimit, input LoadAck);
  modport slave  (input FreqWord, input PhaseWord, input Load, input AtLimit, output LoadAck);
endinterface

// File: rtl/dds_tuning_ctrl_sync.sv
// Per-strobe two-flop synchroniser plus history flop; req pulses for one cycle on each 1->0 edge.
module strobe_sync_edge
  import dds_ctrl_pkg::*;
#(
  parameter int N = NUM_REQ
)(
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] strobeN,
  output logic [N-1:0] req
);

  for (genvar gi = 0; gi < N; gi++) begin : gBit
    logic metaReg;
    logic syncReg;
    logic histReg;

    // Idle level of an active-low strobe is 1, so reset must not fake an edge.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        metaReg <= 1'b1;
        syncReg <= 1'b1;
        histReg <= 1'b1;
      end else begin
        metaReg <= strobeN[gi];
        syncReg <= metaReg;
        histReg <= syncReg;
      end
    end

    assign req[gi] = histReg & ~syncReg;
  end

endmodule

// File: rtl/dds_tuning_ctrl.sv
// DDS tuning-word controller: turns conditioned adjust strobes into clamped frequency and
// wrapped phase updates, handing each word pair to the accumulator through Load/LoadAck.
module dds_tuning_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] STEP_COARSE = DEF_STEP_COARSE,
  parameter logic [WIDTH-1:0] STEP_MICRO  = DEF_STEP_MICRO,
  parameter logic [WIDTH-1:0] STEP_NANO   = DEF_STEP_NANO,
  parameter logic [WIDTH-1:0] PHASE_STEP  = DEF_PHASE_STEP,
  parameter logic [WIDTH-1:0] FREQ_MIN    = DEF_FREQ_MIN,
  parameter logic [WIDTH-1:0] FREQ_MAX    = DEF_FREQ_MAX,
  parameter logic [WIDTH-1:0] FREQ_RESET  = DEF_FREQ_RESET,
  parameter int               ACK_TIMEOUT = DEF_ACK_TIMEOUT
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               Switchadd,
  input  logic               Switchsub,
  input  logic               SwitchMicroadd,
  input  logic               SwitchMicrosub,
  input  logic               SwitchNanoadd,
  input  logic               SwitchNanosub,
  input  logic               Phaseadd,
  input  logic               Phasesub,
  dds_tuning_ctrl_if.master  accBus
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [NUM_REQ-1:0] strobeN;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] pendingReg;
  logic [NUM_REQ-1:0] pendingNext;
  logic [NUM_REQ-1:0] clearMask;
  logic [NUM_REQ-1:0] conflictMask;
  logic [NUM_REQ-1:0] selMask;
  logic [2:0]         selIdx;
  logic [1:0]         stateReg;

  logic [WIDTH-1:0]   freqReg;
  logic [WIDTH-1:0]   phaseReg;
  logic               atLimitReg;
  logic               loadReg;
  logic [CNT_W-1:0]   ackCnt;

  logic [WIDTH-1:0]   stepSel;
  logic [WIDTH:0]     freqSum;
  logic [WIDTH:0]     freqFloor;
  logic [WIDTH-1:0]   freqCalc;
  logic [WIDTH-1:0]   phaseCalc;
  logic               atLimitCalc;

  always_comb begin
    strobeN                 = '1;
    strobeN[IDX_COARSE_ADD] = Switchadd;
    strobeN[IDX_COARSE_SUB] = Switchsub;
    strobeN[IDX_MICRO_ADD]  = SwitchMicroadd;
    strobeN[IDX_MICRO_SUB]  = SwitchMicrosub;
    strobeN[IDX_NANO_ADD]   = SwitchNanoadd;
    strobeN[IDX_NANO_SUB]   = SwitchNanosub;
    strobeN[IDX_PHASE_ADD]  = Phaseadd;
    strobeN[IDX_PHASE_SUB]  = Phasesub;
  end

  strobe_sync_edge #(.N(NUM_REQ)) uSync (
    .clk     (clk),
    .reset   (reset),
    .strobeN (strobeN),
    .req     (req)
  );

  // Opposing requests of one class cancel each other rather than producing two updates.
  for (genvar gi = 0; gi < NUM_REQ / 2; gi++) begin : gConflict
    assign conflictMask[2*gi+1:2*gi] = {2{pendingReg[2*gi] & pendingReg[2*gi+1]}};
  end

  assign selIdx  = pickRequest(pendingReg);
  assign selMask = NUM_REQ'(1) << selIdx;

  always_comb begin
    case (selIdx[2:1])
      2'd0:    stepSel = STEP_COARSE;
      2'd1:    stepSel = STEP_MICRO;
      default: stepSel = STEP_NANO;
    endcase
  end

  assign freqSum   = {1'b0, freqReg} + {1'b0, stepSel};
  assign freqFloor = {1'b0, FREQ_MIN} + {1'b0, stepSel};

  always_comb begin
    freqCalc    = freqReg;
    phaseCalc   = phaseReg;
    atLimitCalc = atLimitReg;
    if (selIdx < IDX_PHASE_ADD) begin
      if (!selIdx[0]) begin
        if (freqSum > {1'b0, FREQ_MAX}) begin
          freqCalc    = FREQ_MAX;
          atLimitCalc = 1'b1;
        end else begin
          freqCalc    = freqSum[WIDTH-1:0];
          atLimitCalc = 1'b0;
        end
      end else begin
        if ({1'b0, freqReg} < freqFloor) begin
          freqCalc    = FREQ_MIN;
          atLimitCalc = 1'b1;
        end else begin
          freqCalc    = freqReg - stepSel;
          atLimitCalc = 1'b0;
        end
      end
    end else if (selIdx == IDX_PHASE_ADD) begin
      phaseCalc = phaseReg + PHASE_STEP;
    end else begin
      phaseCalc = phaseReg - PHASE_STEP;
    end
  end

  // Clear first, then OR in fresh edges, so an edge landing on a bit being cleared survives.
  always_comb begin
    clearMask = '0;
    if (stateReg == ST_IDLE) begin
      clearMask = conflictMask;
    end else if (stateReg == ST_CALC) begin
      clearMask = selMask;
    end
    pendingNext = (pendingReg & ~clearMask) | req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg   <= ST_INIT;
      pendingReg <= '0;
      freqReg    <= FREQ_RESET;
      phaseReg   <= '0;
      atLimitReg <= 1'b0;
      loadReg    <= 1'b0;
      ackCnt     <= '0;
    end else begin
      pendingReg <= pendingNext;
      case (stateReg)
        ST_INIT: begin
          loadReg  <= 1'b1;
          ackCnt   <= '0;
          stateReg <= ST_LOAD;
        end
        ST_IDLE: begin
          if (conflictMask == '0 && pendingReg != '0) begin
            stateReg <= ST_CALC;
          end
        end
        ST_CALC: begin
          freqReg    <= freqCalc;
          phaseReg   <= phaseCalc;
          atLimitReg <= atLimitCalc;
          loadReg    <= 1'b1;
          ackCnt     <= '0;
          stateReg   <= ST_LOAD;
        end
        ST_LOAD: begin
          if (accBus.LoadAck || ackCnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            loadReg  <= 1'b0;
            stateReg <= ST_IDLE;
          end else begin
            ackCnt <= ackCnt + 1'b1;
          end
        end
        default: stateReg <= ST_IDLE;
      endcase
    end
  end

  assign accBus.FreqWord  = freqReg;
  assign accBus.PhaseWord = phaseReg;
  assign accBus.Load      = loadReg;
  assign accBus.AtLimit   = atLimitReg;

endmodule
